// File: rtl/rf_sched_pkg.sv
// Shared types and defaults for the register-file write scheduler.
package rf_sched_pkg;

   localparam logic [4:0] REG_ZERO     = 5'd0;
   localparam int         LINK_REG_DEF = 31;
   localparam int         DEPTH_DEF    = 4;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_req_t;

   function automatic logic addr_hit(input logic v, input logic [4:0] a, input logic [4:0] b);
      return v && (a == b);
   endfunction

endpackage

// File: rtl/rf_pend_fifo.sv
// Pending-write buffer: up to two pushes and one pop per cycle, with per-entry
// valid/addr exposed so the top can compare every pending write against decode reads.
module rf_pend_fifo
   import rf_sched_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push0,
   input  wr_req_t               push0_req,
   input  logic                  push1,
   input  wr_req_t               push1_req,
   input  logic                  pop,
   output wr_req_t               head,
   output logic [CW-1:0]         count,
   output logic [DEPTH-1:0]      ent_valid,
   output logic [DEPTH-1:0][4:0] ent_addr
);

   wr_req_t       mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] wr_ptr_nxt1;

   // push1 is only ever used together with push0, so it always lands one slot later
   assign wr_ptr_nxt1 = wr_ptr + PW'(1);
   assign head        = mem[rd_ptr];

   always_comb begin
      for (int i = 0; i < DEPTH; i++) ent_addr[i] = mem[i].addr;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         ent_valid <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (pop) begin
            ent_valid[rd_ptr] <= 1'b0;
            rd_ptr            <= rd_ptr + PW'(1);
         end
         if (push0) begin
            mem[wr_ptr]       <= push0_req;
            ent_valid[wr_ptr] <= 1'b1;
         end
         if (push1) begin
            mem[wr_ptr_nxt1]       <= push1_req;
            ent_valid[wr_ptr_nxt1] <= 1'b1;
         end
         wr_ptr <= wr_ptr + PW'(push0) + PW'(push1);
         count  <= count + CW'(push0) + CW'(push1) - CW'(pop);
      end
   end

endmodule

// File: rtl/rf_write_sched.sv
// Register-file write scheduler: arbitrates wb, link and MDU writes onto one
// registered write port, buffering displaced wb/link writes in program order.
module rf_write_sched
   import rf_sched_pkg::*;
#(
   parameter int DEPTH    = DEPTH_DEF,
   parameter int LINK_REG = LINK_REG_DEF,
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          freeze,
   input  logic          wb_valid,
   input  logic [4:0]    wb_addr,
   input  logic [31:0]   wb_data,
   input  logic          link_valid,
   input  logic [31:0]   link_data,
   input  logic          mdu_valid,
   input  logic [4:0]    mdu_addr,
   input  logic [31:0]   mdu_data,
   output logic          mdu_ready,
   input  logic [4:0]    rd_addr1,
   input  logic [4:0]    rd_addr2,
   output logic          hazard1,
   output logic          hazard2,
   output logic          rf_we,
   output logic [4:0]    rf_waddr,
   output logic [31:0]   rf_wdata,
   output logic          stall,
   output logic [CW-1:0] count
);

   localparam logic [4:0] LINK_ADDR = 5'(LINK_REG);

   logic                  wb_ok, link_ok, mdu_ok, empty;
   logic                  gnt, pop, push0, push1;
   wr_req_t               wb_req, link_req, mdu_req, head, gnt_req, push0_req, push1_req;
   logic [DEPTH-1:0]      ent_valid;
   logic [DEPTH-1:0][4:0] ent_addr;
   logic                  h1, h2;

   assign wb_req   = '{addr: wb_addr,   data: wb_data};
   assign link_req = '{addr: LINK_ADDR, data: link_data};
   assign mdu_req  = '{addr: mdu_addr,  data: mdu_data};

   assign empty   = (count == '0);
   assign wb_ok   = wb_valid && (wb_addr != REG_ZERO);
   assign link_ok = link_valid && (LINK_ADDR != REG_ZERO);

   // MDU handshake: the result transfers on a cycle where mdu_valid && mdu_ready.
   // Ready only when nothing else could want the port, so the MDU never needs a buffer slot.
   assign mdu_ready = reset && !freeze && empty && !wb_valid && !link_valid;
   assign mdu_ok    = mdu_valid && mdu_ready && (mdu_addr != REG_ZERO);

   assign stall = (count > CW'(DEPTH - 2));

   always_comb begin
      gnt       = 1'b0;
      gnt_req   = '0;
      pop       = 1'b0;
      push0     = 1'b0;
      push0_req = '0;
      push1     = 1'b0;
      push1_req = '0;
      if (!freeze) begin
         if (!empty) begin
            gnt     = 1'b1;
            gnt_req = head;
            pop     = 1'b1;
            if (wb_ok) begin
               push0     = 1'b1;
               push0_req = wb_req;
               push1     = link_ok;
               push1_req = link_req;
            end else if (link_ok) begin
               push0     = 1'b1;
               push0_req = link_req;
            end
         end else if (wb_ok) begin
            gnt       = 1'b1;
            gnt_req   = wb_req;
            push0     = link_ok;
            push0_req = link_req;
         end else if (link_ok) begin
            gnt     = 1'b1;
            gnt_req = link_req;
         end else if (mdu_ok) begin
            gnt     = 1'b1;
            gnt_req = mdu_req;
         end
      end
   end

   rf_pend_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push0     (push0),
      .push0_req (push0_req),
      .push1     (push1),
      .push1_req (push1_req),
      .pop       (pop),
      .head      (head),
      .count     (count),
      .ent_valid (ent_valid),
      .ent_addr  (ent_addr)
   );

   always_comb begin
      h1 = addr_hit(wb_valid, wb_addr, rd_addr1) || addr_hit(link_valid, LINK_ADDR, rd_addr1)
           || addr_hit(rf_we, rf_waddr, rd_addr1);
      h2 = addr_hit(wb_valid, wb_addr, rd_addr2) || addr_hit(link_valid, LINK_ADDR, rd_addr2)
           || addr_hit(rf_we, rf_waddr, rd_addr2);
      for (int i = 0; i < DEPTH; i++) begin
         h1 = h1 || addr_hit(ent_valid[i], ent_addr[i], rd_addr1);
         h2 = h2 || addr_hit(ent_valid[i], ent_addr[i], rd_addr2);
      end
      hazard1 = reset && (rd_addr1 != REG_ZERO) && h1;
      hazard2 = reset && (rd_addr2 != REG_ZERO) && h2;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         rf_we <= gnt;
         if (gnt) begin
            rf_waddr <= gnt_req.addr;
            rf_wdata <= gnt_req.data;
         end
      end
   end

endmodule
